// File: rtl/sum_issue_stage.sv
// sum_issue_stage
//   Buffers operand pairs in a small FIFO and issues the oldest pair to an
//   external combinational adder. The adder result is captured in a single
//   result register that is offered downstream with a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake (in_a, in_b)
//   adder_in1/adder_in2   FIFO head presented to the adder (zero when empty)
//   adder_sum/adder_carry adder response, combinational from adder_in1/2
//   out_valid/out_ready   result handshake (out_sum, out_carry)
//   level                 FIFO occupancy, 0..DEPTH
//   result_cnt            number of completed result handshakes (wraps)
module sum_issue_stage #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BUS_WIDTH-1:0]     in_a,
    input  logic [BUS_WIDTH-1:0]     in_b,
    output logic [BUS_WIDTH-1:0]     adder_in1,
    output logic [BUS_WIDTH-1:0]     adder_in2,
    input  logic [BUS_WIDTH-1:0]     adder_sum,
    input  logic                     adder_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BUS_WIDTH-1:0]     out_sum,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              result_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    // Operand storage; {a, b} per entry. No reset needed: level gates all use.
    logic [2*BUS_WIDTH-1:0] mem_q [DEPTH];
    logic [2*BUS_WIDTH-1:0] head;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   out_valid_q, out_valid_d;
    logic [BUS_WIDTH-1:0]   out_sum_q, out_sum_d;
    logic                   out_carry_q, out_carry_d;
    logic [31:0]            result_cnt_q, result_cnt_d;

    logic                   push;
    logic                   load;
    logic                   not_empty;
    logic                   handshake;

    assign not_empty = (level_q != '0);
    assign in_ready  = (level_q != FULL_LEVEL);
    assign push      = in_valid && in_ready;
    // The result register is refilled whenever it is empty or being drained.
    assign load      = not_empty && (!out_valid_q || out_ready);
    assign handshake = out_valid_q && out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign adder_in1 = not_empty ? head[2*BUS_WIDTH-1:BUS_WIDTH] : '0;
    assign adder_in2 = not_empty ? head[BUS_WIDTH-1:0]           : '0;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_carry_d  = out_carry_q;
        result_cnt_d = result_cnt_q;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (load) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, load})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_sum_d   = adder_sum;
            out_carry_d = adder_carry;
        end else if (handshake) begin
            // Drained with nothing behind it: data holds, only valid drops.
            out_valid_d = 1'b0;
        end

        if (handshake) begin
            result_cnt_d = result_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_carry_q  <= 1'b0;
            result_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_carry_q  <= out_carry_d;
            result_cnt_q <= result_cnt_d;
        end
    end

    assign level      = level_q;
    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_carry  = out_carry_q;
    assign result_cnt = result_cnt_q;

endmodule

// File: tb/tb_sum_issue_stage.sv
`timescale 1ns/1ps
module tb_sum_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] adder_in1;
    logic [31:0] adder_in2;
    logic [31:0] adder_sum;
    logic        adder_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic [2:0]  level;
    logic [31:0] result_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] exp_q [$];

    sum_issue_stage #(.BUS_WIDTH(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .adder_in1   (adder_in1),
        .adder_in2   (adder_in2),
        .adder_sum   (adder_sum),
        .adder_carry (adder_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carry   (out_carry),
        .level       (level),
        .result_cnt  (result_cnt)
    );

    // External adder the stage feeds.
    assign {adder_carry, adder_sum} = {1'b0, adder_in1} + {1'b0, adder_in2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: results must leave in push order with the right sum/carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {31'd0, out_carry, out_sum}, 64'hDEAD);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    $display("result sum=0x%08h carry=%0d", out_sum, out_carry);
                    check("result", {31'd0, out_carry, out_sum}, {31'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] bp_a [6];
    logic [31:0] bp_b [6];

    initial begin
        int acc;
        int guard;

        bp_a[0] = 32'h0000_0001; bp_b[0] = 32'h0000_0002;
        bp_a[1] = 32'h8000_0000; bp_b[1] = 32'h8000_0000;
        bp_a[2] = 32'h1234_5678; bp_b[2] = 32'h1111_1111;
        bp_a[3] = 32'hFFFF_FFFF; bp_b[3] = 32'hFFFF_FFFF;
        bp_a[4] = 32'h0000_00FF; bp_b[4] = 32'h0000_0001;
        bp_a[5] = 32'hDEAD_BEEF; bp_b[5] = 32'h0000_0001;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready",   {63'd0, in_ready}, 64'd1);
        check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        check("rst_level",      {61'd0, level}, 64'd0);
        check("rst_out_sum",    {32'd0, out_sum}, 64'd0);
        check("rst_out_carry",  {63'd0, out_carry}, 64'd0);
        check("rst_result_cnt", {32'd0, result_cnt}, 64'd0);
        check("rst_adder_in1",  {32'd0, adder_in1}, 64'd0);
        check("rst_adder_in2",  {32'd0, adder_in2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: 0xFFFFFFFF + 1 -> sum 0, carry 1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'hFFFF_FFFF;
        in_b      = 32'h0000_0001;
        tick();
        $display("push a=0x%08h b=0x%08h", in_a, in_b);
        in_valid = 1'b0;
        check("single_level_after_push", {61'd0, level}, 64'd1);
        check("single_adder_in1", {32'd0, adder_in1}, 64'hFFFF_FFFF);
        check("single_adder_in2", {32'd0, adder_in2}, 64'h1);
        check("single_no_early_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("single_out_valid", {63'd0, out_valid}, 64'd1);
        check("single_out_sum",   {32'd0, out_sum}, 64'h0);
        check("single_out_carry", {63'd0, out_carry}, 64'd1);
        check("single_level_empty", {61'd0, level}, 64'd0);
        check("single_adder_zero", {32'd0, adder_in1}, 64'd0);
        tick();
        check("single_result_cnt", {32'd0, result_cnt}, 64'd1);
        check("single_valid_clear", {63'd0, out_valid}, 64'd0);
        check("single_sum_hold",   {32'd0, out_sum}, 64'h0);
        check("single_carry_hold", {63'd0, out_carry}, 64'd1);

        // Backpressure fill: 6 offered, 5 accepted
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = bp_a[i];
            in_b     = bp_b[i];
            if (in_ready) acc++;
            tick();
            $display("offer a=0x%08h b=0x%08h level=%0d", bp_a[i], bp_b[i], level);
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd5);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_level", {61'd0, level}, 64'd4);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_head_sum", {32'd0, out_sum}, 64'h3);

        // Stall: result held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_sum",   {32'd0, out_sum}, 64'h3);
            check("stall_carry", {63'd0, out_carry}, 64'd0);
            check("stall_cnt",   {32'd0, result_cnt}, 64'd1);
            check("stall_valid", {63'd0, out_valid}, 64'd1);
        end

        // Push+pop attempt while full: push refused, level drops to 3
        in_valid  = 1'b1;
        in_a      = 32'h0000_0010;
        in_b      = 32'h0000_0020;
        out_ready = 1'b1;
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        check("full_pushpop_level", {61'd0, level}, 64'd3);
        in_valid = 1'b0;
        tick();
        check("drain_level2", {61'd0, level}, 64'd2);
        // Push+pop at level 2 leaves level 2
        in_valid = 1'b1;
        in_a     = 32'h7000_0000;
        in_b     = 32'h9000_0001;
        tick();
        in_valid = 1'b0;
        check("pushpop_level2", {61'd0, level}, 64'd2);
        check("pushpop_valid", {63'd0, out_valid}, 64'd1);
        guard = 0;
        while (level != 0 && guard < 10) begin
            tick();
            check("drain_no_gap", {63'd0, out_valid}, 64'd1);
            guard++;
        end
        check("drain_bounded", 64'(guard < 10), 64'd1);
        tick();
        check("drain_done_valid", {63'd0, out_valid}, 64'd0);
        check("drain_result_cnt", {32'd0, result_cnt}, 64'd7);

        // Streaming: 100 cycles, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            tick();
            check("stream_level", 64'(level <= 3'd1), 64'd1);
            if (i >= 1) check("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_result_cnt", {32'd0, result_cnt}, 64'd107);
        check("stream_done_valid", {63'd0, out_valid}, 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with level 3 and a pending result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h100 + 32'(i);
            in_b     = 32'h1;
            tick();
        end
        in_valid = 1'b0;
        check("mid_level3", {61'd0, level}, 64'd3);
        check("mid_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", {61'd0, level}, 64'd0);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_sum",   {32'd0, out_sum}, 64'd0);
        check("mid_rst_carry", {63'd0, out_carry}, 64'd0);
        check("mid_rst_cnt",   {32'd0, result_cnt}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_adder", {32'd0, adder_in1}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h5;
        in_b      = 32'h3;
        tick();
        in_valid = 1'b0;
        check("post_rst_level", {61'd0, level}, 64'd1);
        tick();
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_sum",   {32'd0, out_sum}, 64'h8);
        check("post_rst_carry", {63'd0, out_carry}, 64'd0);
        tick();
        check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        check("post_rst_cnt", {32'd0, result_cnt}, 64'd1);
        check("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_issue_stage.md
SUM_ISSUE_STAGE -- requirements
Module: sum_issue_stage

Interface
REQ-001 Parameter BUS_WIDTH, default 32, operand and result width in bits; SHALL match the adder it feeds.
REQ-002 Parameter DEPTH, default 4, operand FIFO entries; SHALL be a power of two >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  stage can accept an operand pair.
REQ-007 in_a  input  BUS_WIDTH  first operand.
REQ-008 in_b  input  BUS_WIDTH  second operand.
REQ-009 adder_in1  output  BUS_WIDTH  drives the adder's sum_in1.
REQ-010 adder_in2  output  BUS_WIDTH  drives the adder's sum_in2.
REQ-011 adder_sum  input  BUS_WIDTH  adder's sum_out, combinational from adder_in1/adder_in2.
REQ-012 adder_carry  input  1  adder's carry_bit_out.
REQ-013 out_valid  output  1  result register holds an unconsumed result.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_sum  output  BUS_WIDTH  registered sum.
REQ-016 out_carry  output  1  registered carry.
REQ-017 level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-018 result_cnt  output  32  count of completed output handshakes.

Function
REQ-019 Push occurs on a rising edge where in_valid && in_ready; {in_a, in_b} is written at the write pointer.
REQ-020 in_ready SHALL equal (level != DEPTH), combinational; no push when full even if a pop occurs that cycle.
REQ-021 adder_in1/adder_in2 SHALL present the FIFO head entry combinationally when level > 0, and all-zero when level == 0.
REQ-022 Load condition: level > 0 && (!out_valid || out_ready); on that edge, out_sum <= adder_sum, out_carry <= adder_carry, out_valid <= 1, and the head is popped.
REQ-023 When out_valid && out_ready && level == 0, out_valid SHALL clear on that edge; out_sum/out_carry hold their values.
REQ-024 When out_valid && !out_ready, out_valid, out_sum and out_carry SHALL hold unchanged.
REQ-025 Simultaneous push and pop in one edge: level unchanged, both pointers advance.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; level is tracked separately, so full and empty are unambiguous.
REQ-027 Latency: a pair pushed on edge t into an empty FIFO with a free result register SHALL appear with out_valid = 1 after edge t+1.
REQ-028 Throughput: one result per cycle sustained while in_valid and out_ready are held high.
REQ-029 Results SHALL leave in push order; no drop, no duplication.
REQ-030 result_cnt SHALL increment by 1 on each edge with out_valid && out_ready, wrapping 0xFFFFFFFF -> 0.
REQ-031 Input signals outside a handshake SHALL have no effect on state.

Reset
REQ-032 While rst_n is low, asynchronously: pointers = 0, level = 0, out_valid = 0, out_sum = 0, out_carry = 0, result_cnt = 0; hence in_ready = 1 and adder_in1/adder_in2 = 0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO entries and any pending result; no stale result appears after release.
REQ-034 First push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Single op: push a=0xFFFFFFFF, b=0x00000001, out_ready=1 -> after edge t+1 out_valid=1, out_sum=0x00000000, out_carry=1; result_cnt=1 one edge later.
REQ-036 Backpressure fill: out_ready=0, push 6 pairs back-to-back -> 5 accepted (4 FIFO + 1 result register), in_ready=0, level=4; raising out_ready drains all 5 in order with no gaps.
REQ-037 Streaming: in_valid=1 and out_ready=1 for 100 cycles with random operands -> 100 results matching (a+b) mod 2^32 and carry, one per cycle, level never above 1.
REQ-038 Simultaneous push/pop at level=4: no push accepted (in_ready=0), level becomes 3 after edge; at level=2, push+pop leaves level=2.
REQ-039 Reset mid-stream: level=3, out_valid=1, assert rst_n low for 1 cycle -> all outputs at reset values; after release, next push 0x5+0x3 yields out_sum=0x8, out_carry=0.
REQ-040 Idle/stall: out_valid=1, out_ready=0 for 10 cycles -> out_sum/out_carry stable, result_cnt unchanged.
